// File: rtl/sprite_pos_ctrl_if.sv
// Board-side signal bundle for the sprite position controller: raw DE2
// buttons and vsync in, sprite coordinates and debounced button flags out.
interface sprite_pos_ctrl_if;
  logic       iUP;
  logic       iDOWN;
  logic       iLEFT;
  logic       iRIGHT;
  logic       iVS;
  logic [9:0] oX;
  logic [8:0] oY;
  logic       oMOVED;
  logic [3:0] oBTN;

  modport master (
    output iUP, iDOWN, iLEFT, iRIGHT, iVS,
    input  oX, oY, oMOVED, oBTN
  );

  modport slave (
    input  iUP, iDOWN, iLEFT, iRIGHT, iVS,
    output oX, oY, oMOVED, oBTN
  );
endinterface

// File: rtl/sprite_pos_ctrl.sv
// Sprite position controller: debounced DE2 buttons move a sprite once per
// VGA frame, saturating at the screen edges and accelerating on long holds.

module sprite_pos_axis #(
  parameter int W            = 10,
  parameter int STEP         = 2,
  parameter int ACCEL_FRAMES = 30,
  parameter int LIMIT        = 608,
  parameter int INIT         = 304
) (
  input  logic         iCLK,
  input  logic         iRST_n,
  input  logic         tick,
  input  logic         upd,
  input  logic         btn_neg,
  input  logic         btn_pos,
  output logic [W-1:0] pos,
  output logic         changed
);
  typedef enum logic [1:0] {IDLE, MOVE_NEG, MOVE_POS} state_e;

  localparam logic [5:0] HOLD_MAX  = 6'(ACCEL_FRAMES);
  localparam logic [W:0] STEP_BASE = (W+1)'(STEP);
  localparam logic [W:0] STEP_FAST = (W+1)'(2 * STEP);
  localparam logic [W:0] POS_LIMIT = (W+1)'(LIMIT);

  state_e       state_q, state_d, dir;
  logic [5:0]   hold_q, hold_d;
  logic [W-1:0] pos_q, pos_d;
  logic [W:0]   step, pos_ext, sum, diff;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      pos_q   <= W'(INIT);
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pos_q   <= pos_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pos_d   = pos_q;
    dir     = IDLE;
    step    = (hold_q >= HOLD_MAX) ? STEP_FAST : STEP_BASE;
    pos_ext = {1'b0, pos_q};
    sum     = pos_ext + step;
    diff    = pos_ext - step;

    if (btn_neg && !btn_pos) begin
      dir = MOVE_NEG;
    end else if (btn_pos && !btn_neg) begin
      dir = MOVE_POS;
    end

    if (tick) begin
      state_d = dir;
      if (dir == IDLE || dir != state_q) begin
        hold_d = '0;
      end else if (hold_q < HOLD_MAX) begin
        hold_d = hold_q + 6'd1;
      end
    end

    // Extra MSB of diff/sum flags underflow and overflow past the limit.
    if (upd) begin
      case (state_q)
        MOVE_NEG: pos_d = diff[W] ? '0 : diff[W-1:0];
        MOVE_POS: pos_d = (sum > POS_LIMIT) ? POS_LIMIT[W-1:0] : sum[W-1:0];
        default:  pos_d = pos_q;
      endcase
    end
  end

  assign pos     = pos_q;
  assign changed = (pos_d != pos_q);
endmodule

module sprite_pos_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int STEP            = 2,
  parameter int ACCEL_FRAMES    = 30,
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int SPRITE_W        = 32,
  parameter int SPRITE_H        = 32,
  parameter int X_INIT          = 304,
  parameter int Y_INIT          = 224
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  sprite_pos_ctrl_if.slave  bus
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0] btn_raw, btn_sync1_q, btn_sync1_d, btn_sync2_q, btn_sync2_d;
  logic [3:0] btn_level, btn_pressed;
  logic       vs_sync1_q, vs_sync1_d, vs_sync2_q, vs_sync2_d, vs_prev_q, vs_prev_d;
  logic       upd_q, upd_d, moved_q, moved_d, tick;
  logic       x_changed, y_changed;
  logic [9:0] x_pos;
  logic [8:0] y_pos;

  assign btn_raw = {bus.iUP, bus.iDOWN, bus.iLEFT, bus.iRIGHT};

  always_comb begin
    btn_sync1_d = btn_raw;
    btn_sync2_d = btn_sync1_q;
    vs_sync1_d  = bus.iVS;
    vs_sync2_d  = vs_sync1_q;
    vs_prev_d   = vs_sync2_q;
    tick        = vs_prev_q & ~vs_sync2_q;
    upd_d       = tick;
    moved_d     = upd_q & (x_changed | y_changed);
  end

  // Synchronizers and edge history reset high so no tick fires out of reset.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      btn_sync1_q <= '1;
      btn_sync2_q <= '1;
      vs_sync1_q  <= 1'b1;
      vs_sync2_q  <= 1'b1;
      vs_prev_q   <= 1'b1;
      upd_q       <= 1'b0;
      moved_q     <= 1'b0;
    end else begin
      btn_sync1_q <= btn_sync1_d;
      btn_sync2_q <= btn_sync2_d;
      vs_sync1_q  <= vs_sync1_d;
      vs_sync2_q  <= vs_sync2_d;
      vs_prev_q   <= vs_prev_d;
      upd_q       <= upd_d;
      moved_q     <= moved_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
      logic [CW-1:0] cnt_q, cnt_d;
      logic          level_q, level_d;

      always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (btn_sync2_q[gi] == level_q) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          level_d = btn_sync2_q[gi];
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
          cnt_q   <= '0;
          level_q <= 1'b1;
        end else begin
          cnt_q   <= cnt_d;
          level_q <= level_d;
        end
      end

      assign btn_level[gi] = level_q;
    end
  endgenerate

  assign btn_pressed = ~btn_level;

  sprite_pos_axis #(
    .W(10), .STEP(STEP), .ACCEL_FRAMES(ACCEL_FRAMES),
    .LIMIT(H_ACTIVE - SPRITE_W), .INIT(X_INIT)
  ) u_axis_x (
    .iCLK(iCLK), .iRST_n(iRST_n), .tick(tick), .upd(upd_q),
    .btn_neg(btn_pressed[1]), .btn_pos(btn_pressed[0]),
    .pos(x_pos), .changed(x_changed)
  );

  sprite_pos_axis #(
    .W(9), .STEP(STEP), .ACCEL_FRAMES(ACCEL_FRAMES),
    .LIMIT(V_ACTIVE - SPRITE_H), .INIT(Y_INIT)
  ) u_axis_y (
    .iCLK(iCLK), .iRST_n(iRST_n), .tick(tick), .upd(upd_q),
    .btn_neg(btn_pressed[3]), .btn_pos(btn_pressed[2]),
    .pos(y_pos), .changed(y_changed)
  );

  assign bus.oX     = x_pos;
  assign bus.oY     = y_pos;
  assign bus.oMOVED = moved_q;
  assign bus.oBTN   = btn_pressed;
endmodule

// File: doc/sprite_pos_ctrl.md
SPRITE_POS_CTRL -- requirements
Module: sprite_pos_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as in the codebase: iCLK and iRST_n.
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000: consecutive stable cycles needed to accept a button level (10 ms at 25 MHz).
REQ-003 Parameter STEP, default 2: base pixels moved per frame.
REQ-004 Parameter ACCEL_FRAMES, default 30: consecutive held frames after which the step doubles.
REQ-005 Parameters H_ACTIVE=640, V_ACTIVE=480, SPRITE_W=32, SPRITE_H=32: screen and sprite size in pixels.
REQ-006 Parameters X_INIT=304, Y_INIT=224: reset position of the sprite.
REQ-007 iCLK  input  1  VGA pixel clock, the same clock as vga_controller.
REQ-008 iRST_n  input  1  asynchronous active-low reset.
REQ-009 iUP, iDOWN, iLEFT, iRIGHT  input  1 each  raw DE2 pushbuttons, active-low, asynchronous to iCLK.
REQ-010 iVS  input  1  active-low vertical sync taken from vga_controller oVS.
REQ-011 oX  output  10  sprite top-left x, consumed by vga_controller.
REQ-012 oY  output  9  sprite top-left y, consumed by vga_controller.
REQ-013 oMOVED  output  1  one-cycle pulse when oX or oY changes.
REQ-014 oBTN  output  4  debounced pressed flags {up,down,left,right}, active-high.

Function
REQ-015 Each button and iVS SHALL pass through a 2-flop synchronizer, reset to 1 (released / not in sync).
REQ-016 Each button SHALL have its own debounce counter:
- Clear the counter whenever the synchronized level equals the accepted level.
- Otherwise increment the counter.
- When the counter reaches DEBOUNCE_CYCLES-1, the new level is accepted and the counter clears.
- Counter width: clog2(DEBOUNCE_CYCLES).
REQ-017 Latency from a stable raw button edge to the oBTN change SHALL be exactly DEBOUNCE_CYCLES+2 cycles.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT change oBTN.
REQ-019 A frame tick SHALL be a one-cycle pulse on each 1->0 transition of the synchronized iVS.
- Exactly one tick per frame.
- No tick on the first cycle after reset.
REQ-020 Axis FSM states: IDLE, MOVE_NEG, MOVE_POS. The state is evaluated only on a frame tick, from the oBTN values at that cycle:
- Only up (y) or only left (x) pressed -> MOVE_NEG.
- Only down or only right pressed -> MOVE_POS.
- Neither or both pressed -> IDLE.
REQ-021 Per-axis hold counter (6 bits, saturating at ACCEL_FRAMES):
- Increment on a tick when the state stays the same non-IDLE direction.
- Clear to 0 on IDLE or on a direction change.
REQ-022 Step per tick SHALL be STEP while hold < ACCEL_FRAMES, and 2*STEP once hold = ACCEL_FRAMES.
REQ-023 Position update SHALL occur on the cycle after the tick. Saturate at the limits, never wrap:
- MOVE_NEG: pos = max(pos-step, 0).
- MOVE_POS: pos = min(pos+step, LIMIT), where x LIMIT = H_ACTIVE-SPRITE_W = 608 and y LIMIT = V_ACTIVE-SPRITE_H = 448.
- Compute with 1 extra bit to detect underflow and overflow.
REQ-024 oX and oY SHALL change only in the update cycle. Because the update follows the start of vsync, the position is stable for the whole active frame.
REQ-025 oMOVED SHALL be 1 in the update cycle if either coordinate changed, else 0.
- A saturated press at a limit produces no pulse.

Reset
REQ-026 While iRST_n=0, the block SHALL hold these values; reset assertion is asynchronous, release takes effect on the next iCLK edge:
- oX=X_INIT, oY=Y_INIT.
- oBTN=4'b0000, oMOVED=0.
- Both axis FSMs IDLE, hold counters 0, debounce counters 0.
- Synchronizers 1.
REQ-027 Reset asserted mid-frame or mid-debounce SHALL discard all pending state. There SHALL be no position update until the first tick after release.

Verification (bench overrides DEBOUNCE_CYCLES=16, drives iVS low for 2 cycles every 200 cycles)
REQ-028 Reset -> oX=304, oY=224, oBTN=0, oMOVED=0. Hold for 3 frames with no buttons -> no oMOVED pulse.
REQ-029 iRIGHT low continuously -> oBTN[0]=1 exactly 18 cycles after the edge. Then oX goes 306, 308, ... one update per frame. After 30 frames of hold, oX increments by 4 per frame.
REQ-030 iLEFT pulsed low for 10 cycles -> oBTN unchanged, oX unchanged.
REQ-031 iUP held from oY=224 -> oY decreases to 0 and stays 0. oMOVED stops pulsing once oY=0.
REQ-032 iUP and iDOWN held together -> oY constant, y hold counter 0. Release iDOWN -> oY decreases at STEP=2 (no acceleration carried over).
REQ-033 iRST_n pulsed low mid-frame while iRIGHT is held -> outputs return to 304/224 immediately. The first change after release occurs in the cycle after the next tick that follows debounce completion.
